// File: rtl/dcache_pkg.sv
// Shared constants, FSM state type and address field helpers for the data cache.
package dcache_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned INDEX_W   = 3;
  localparam int unsigned OFFSET_W  = 2;
  localparam int unsigned TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned NumBlocks = 1 << INDEX_W;
  localparam int unsigned BlockW    = 8 << OFFSET_W;
  localparam int unsigned MemAddrW  = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    StIdle,
    StWriteback,
    StFetch,
    StAllocate
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return TAG_W'(addr >> (INDEX_W + OFFSET_W));
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return INDEX_W'(addr >> OFFSET_W);
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return OFFSET_W'(addr);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped line storage: valid/dirty/tag/data per block, a block-fill port,
// a byte-store port and a combinational read of the indexed line.
module dcache_array
  import dcache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [INDEX_W-1:0]  index_i,
  input  logic [OFFSET_W-1:0] offset_i,
  input  logic                blk_we_i,
  input  logic [TAG_W-1:0]    blk_tag_i,
  input  logic [BlockW-1:0]   blk_data_i,
  input  logic                byte_we_i,
  input  logic [7:0]          byte_data_i,
  output logic                valid_o,
  output logic                dirty_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic [BlockW-1:0]   data_o
);

  logic [NumBlocks-1:0] valid_q;
  logic [NumBlocks-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NumBlocks];
  logic [BlockW-1:0]    data_q [NumBlocks];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (blk_we_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (byte_we_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  // Payload is only meaningful behind valid, so it is never cleared; reset still blocks writes.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (blk_we_i) begin
        tag_q[index_i]  <= blk_tag_i;
        data_q[index_i] <= blk_data_i;
      end else if (byte_we_i) begin
        data_q[index_i][{offset_i, 3'b000} +: 8] <= byte_data_i;
      end
    end
  end

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign data_o  = data_q[index_i];

endmodule

// File: rtl/dcache_controller.sv
// Write-back, write-allocate direct-mapped data cache: hit logic plus the miss FSM
// that writes back dirty victims, fetches the missing block and allocates it.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                READ,
  input  logic                WRITE,
  input  logic [ADDR_W-1:0]   ADDRESS,
  input  logic [7:0]          WRITEDATA,
  output logic [7:0]          READDATA,
  output logic                BUSYWAIT,
  output logic                mem_read,
  output logic                mem_write,
  output logic [MemAddrW-1:0] mem_address,
  output logic [BlockW-1:0]   mem_writedata,
  input  logic [BlockW-1:0]   mem_readdata,
  input  logic                mem_busywait
);

  state_e state_q, state_d;
  logic   issued_q, issued_d;
  logic [BlockW-1:0] fill_q, fill_d;

  logic                req, hit, xfer_done;
  logic                blk_we, byte_we;
  logic                line_valid, line_dirty;
  logic [TAG_W-1:0]    req_tag, line_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_offset;
  logic [BlockW-1:0]   line_data;

  assign req_tag    = addr_tag(ADDRESS);
  assign req_index  = addr_index(ADDRESS);
  assign req_offset = addr_offset(ADDRESS);

  dcache_array u_array (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .index_i     (req_index),
    .offset_i    (req_offset),
    .blk_we_i    (blk_we),
    .blk_tag_i   (req_tag),
    .blk_data_i  (fill_q),
    .byte_we_i   (byte_we),
    .byte_data_i (WRITEDATA),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .tag_o       (line_tag),
    .data_o      (line_data)
  );

  assign req       = READ | WRITE;
  assign hit       = line_valid & (line_tag == req_tag);
  // A transfer is presented for at least one cycle before memory may complete it.
  assign xfer_done = issued_q & ~mem_busywait;

  assign BUSYWAIT      = ~RESET & req & ~((state_q == StIdle) & hit);
  assign READDATA      = ((state_q == StIdle) && hit && READ) ?
                         line_data[{req_offset, 3'b000} +: 8] : 8'h00;
  assign mem_writedata = line_data;

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    fill_d      = fill_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = {req_tag, req_index};
    blk_we      = 1'b0;
    byte_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        byte_we = WRITE & hit;
        if (req && !hit) begin
          state_d = (line_valid && line_dirty) ? StWriteback : StFetch;
        end
      end
      StWriteback: begin
        mem_write   = 1'b1;
        mem_address = {line_tag, req_index};
        if (xfer_done) begin
          issued_d = 1'b0;
          state_d  = StFetch;
        end else begin
          issued_d = 1'b1;
        end
      end
      StFetch: begin
        mem_read = 1'b1;
        if (xfer_done) begin
          issued_d = 1'b0;
          fill_d   = mem_readdata;
          state_d  = StAllocate;
        end else begin
          issued_d = 1'b1;
        end
      end
      StAllocate: begin
        blk_we  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
    end
  end

  always_ff @(posedge CLK) begin
    fill_q <= fill_d;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache with its controller FSM.
- Sits between the CPU datapath (driven by mem_read/mem_write decoded for lwi/lwd/swi/swd) and the multi-cycle data memory.
- Stalls the CPU via BUSYWAIT on a miss, writes back dirty victims, fetches the missing block, then completes the access.

Parameters:
- ADDR_W, 8, CPU byte-address width.
- INDEX_W, 3, block index bits (8 blocks).
- OFFSET_W, 2, byte offset bits (4-byte blocks); TAG_W = ADDR_W-INDEX_W-OFFSET_W = 3.

Ports:
- CLK  in  1  clock, all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- ADDRESS  in  8  CPU byte address {tag,index,offset}.
- WRITEDATA  in  8  store data.
- READDATA  out  8  load data.
- BUSYWAIT  out  1  CPU stall.
- mem_read  out  1  block read request to memory.
- mem_write  out  1  block write request to memory.
- mem_address  out  6  block address {tag,index}.
- mem_writedata  out  32  victim block, byte0 in [7:0].
- mem_readdata  in  32  fetched block, byte0 in [7:0].
- mem_busywait  in  1  memory busy.

Behaviour:
- Storage per block: valid, dirty, tag[2:0], data[31:0].
- hit = valid[index] & (tag[index]==ADDRESS tag), combinational.
- Reset (RESET high at an edge):
  - all valid and dirty bits cleared; data and tags need no reset.
  - state=IDLE; issued flag cleared.
  - mem_read=mem_write=0; BUSYWAIT=0 while RESET high.
  - Reset mid-transfer abandons the transfer: memory requests drop on the next cycle and no array update occurs.
- FSM states: IDLE, WRITEBACK, FETCH, ALLOCATE.
- IDLE:
  - No request: BUSYWAIT=0, mem_read=mem_write=0.
  - Read hit: READDATA = selected byte, combinational, same cycle; BUSYWAIT=0; zero stall.
  - Write hit: byte updated and dirty set at the next edge; BUSYWAIT=0.
  - Miss with valid & dirty victim: BUSYWAIT=1 in the same cycle; go to WRITEBACK.
  - Miss otherwise: BUSYWAIT=1 in the same cycle; go to FETCH.
- WRITEBACK:
  - mem_write=1; mem_address={victim tag,index}; mem_writedata=victim block.
  - Complete at the first edge where issued=1 and mem_busywait=0 (at least one cycle presented); then go to FETCH.
- FETCH:
  - mem_read=1; mem_address={ADDRESS tag,index}.
  - Completes under the same rule as WRITEBACK; capture mem_readdata and go to ALLOCATE.
- ALLOCATE:
  - One cycle: write the block, tag and valid=1, dirty=0; go to IDLE.
  - The retried access then hits in IDLE, and a store sets dirty on that edge.
- BUSYWAIT = (READ|WRITE) & !(state==IDLE & hit), forced to 0 during reset.
- READ and WRITE both high is treated as a write.
- A request deasserted mid-miss still completes the fill, then returns to IDLE.
- Miss latency = (WB cycles if dirty) + fetch cycles + 1 ALLOCATE + 1 hit cycle.
- mem_read and mem_write are never high together.
- READDATA = 8'h00 when not (IDLE & hit & READ).

Decomposition:
- Package dcache_pkg holds:
  - state enum {IDLE, WRITEBACK, FETCH, ALLOCATE};
  - ADDR_W, INDEX_W, OFFSET_W and TAG_W constants;
  - field-extract helper functions for tag, index and offset.
- Sub-module dcache_array: valid/dirty/tag/data storage with one block-write port and one byte-write port, plus combinational read.
- The FSM and hit logic stay in dcache_controller.

Test Plan:
- Reset, then READ ADDRESS=8'h05 (memory block 1 = 32'hDDCCBBAA, 5-cycle memory) -> BUSYWAIT=1 same cycle, no mem_write, mem_read with mem_address=6'h01; after fill, READDATA=8'hBB and BUSYWAIT=0.
- Repeat READ 8'h05, then READ 8'h07 -> both hit, BUSYWAIT=0 throughout, READDATA=8'hBB then 8'hDD, mem_read never asserts.
- WRITE 8'h06 with WRITEDATA=8'h5A (block resident) -> no stall, dirty[1]=1; then READ 8'h25 (same index, tag 1) -> mem_write with mem_address=6'h01 and mem_writedata=32'hDD5ABBAA, then mem_read with mem_address=6'h09.
- WRITE miss to 8'h40 on a clean, invalid index -> fetch only (no writeback); after ALLOCATE the store lands, dirty=1, and the byte reads back.
- RESET asserted during FETCH cycle 3 -> mem_read=0 next cycle, state=IDLE, all valid=0; a re-read of 8'h05 misses again.
- Memory with zero-wait behaviour (mem_busywait held low) -> each transfer still lasts at least one cycle; mem_read and mem_write never overlap.
